// File: rtl/chunk_add_pkg.sv
// Shared types and helpers for the chunk-serial adder sequencer.
package chunk_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} chunk_state_t;

   // Width of a counter that indexes k chunks, never narrower than one bit
   function automatic int cnt_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/chunk_shreg.sv
// W-bit register with parallel load and a right shift by N that inserts an N-bit chunk at the top.
module chunk_shreg #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   input  logic [N-1:0] ins,
   output logic [W-1:0] q,
   output logic [N-1:0] q_lo
);

   logic [W-1:0] q_reg;
   logic [W-1:0] shifted;

   // With a single chunk the whole register is replaced by the insert
   generate
      if (W == N) begin : g_single
         assign shifted = ins;
      end else begin : g_multi
         assign shifted = {ins, q_reg[W-1:N]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= din;
      end else if (shift) begin
         q_reg <= shifted;
      end
   end

   assign q    = q_reg;
   assign q_lo = q_reg[N-1:0];

endmodule

// File: rtl/chunk_serial_add_ctrl.sv
// Streams two W-bit operands LSB chunk first through an external N-bit adder slice and assembles the sum.
module chunk_serial_add_ctrl
   import chunk_add_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] operA,
   input  logic [W-1:0] operB,
   input  logic         Cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] resultOUT,
   output logic         Cout,
   output logic [N-1:0] add_a,
   output logic [N-1:0] add_b,
   output logic         add_cin,
   input  logic [N-1:0] add_sum,
   input  logic         add_cout
);

   localparam int K  = W / N;
   localparam int CW = cnt_width(K);

   generate
      if ((W % N) != 0 || W < N) begin : g_bad_params
         $error("chunk_serial_add_ctrl: W must be a positive multiple of N");
      end
   endgenerate

   chunk_state_t  state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic          carry_reg;
   logic          hs;
   logic          run;
   logic [N-1:0]  a_lo, b_lo;
   logic [W-1:0]  res_q;

   assign hs  = in_valid && in_ready;
   assign run = (state_reg == RUN);

   chunk_shreg #(.W(W), .N(N)) a_sr (
      .clk(clk), .rst_n(rst_n), .load(hs), .shift(run),
      .din(operA), .ins('0), .q(), .q_lo(a_lo)
   );

   chunk_shreg #(.W(W), .N(N)) b_sr (
      .clk(clk), .rst_n(rst_n), .load(hs), .shift(run),
      .din(operB), .ins('0), .q(), .q_lo(b_lo)
   );

   // Sum chunks enter at the top so after K shifts the first chunk sits at bit 0
   chunk_shreg #(.W(W), .N(N)) res_sr (
      .clk(clk), .rst_n(rst_n), .load(hs), .shift(run),
      .din('0), .ins(add_sum), .q(res_q), .q_lo()
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (hs) begin
            carry_reg <= Cin;
            cnt_reg   <= '0;
         end else if (run) begin
            carry_reg <= add_cout;
            cnt_reg   <= cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      resultOUT  = '0;
      Cout       = 1'b0;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            add_a   = a_lo;
            add_b   = b_lo;
            add_cin = carry_reg;
            if (cnt_reg == CW'(K - 1)) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            resultOUT = res_q;
            Cout      = carry_reg;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_chunk_serial_add_ctrl.sv
// Directed bench for chunk_serial_add_ctrl: a 16/4 instance and a 4/4 instance, each driving a behavioural adder slice.
module tb_chunk_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // 16-bit / 4-bit chunk instance
   logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
   logic [15:0] opa = '0, opb = '0;
   logic        in_ready, out_valid, cout;
   logic [15:0] result;
   logic [3:0]  add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   chunk_serial_add_ctrl #(.W(16), .N(4)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .operA(opa), .operB(opb), .Cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .resultOUT(result), .Cout(cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // Single-chunk instance
   logic       in_valid4 = 1'b0, cin4 = 1'b0;
   logic [3:0] opa4 = '0, opb4 = '0;
   logic       in_ready4, out_valid4, cout4;
   logic [3:0] result4;
   logic [3:0] add_a4, add_b4, add_sum4;
   logic       add_cin4, add_cout4;

   assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

   chunk_serial_add_ctrl #(.W(4), .N(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .operA(opa4), .operB(opb4), .Cin(cin4),
      .out_valid(out_valid4), .out_ready(1'b1),
      .resultOUT(result4), .Cout(cout4),
      .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
      .add_sum(add_sum4), .add_cout(add_cout4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One full transaction on dut16; caller is aligned to a negedge with the DUT idle
   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] er, input logic ec,
                        input logic [3:0] eseq, input int hold);
      logic [3:0] seq;
      seq       = '0;
      in_valid  = 1'b1;
      opa       = a;
      opb       = b;
      cin       = c;
      out_ready = (hold == 0);
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      opa      = ~a;
      opb      = ~b;
      cin      = ~c;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            chk({tag, "_add_a_first"}, 32'(add_a), 32'(a[3:0]));
            chk({tag, "_add_b_first"}, 32'(add_b), 32'(b[3:0]));
         end
         chk({tag, "_out_valid_run"}, 32'(out_valid), 32'd0);
         chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
         seq[i] = add_cin;
         @(negedge clk);
      end
      chk({tag, "_cin_seq"}, 32'(seq), 32'(eseq));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_result"}, 32'(result), 32'(er));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_result"}, 32'(result), 32'(er));
         chk({tag, "_hold_cout"}, 32'(cout), 32'(ec));
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_idle_result"}, 32'(result), 32'd0);
      $display("txn %s: A=%h B=%h Cin=%b -> result=%h Cout=%b cin_seq=%b",
               tag, a, b, c, er, ec, seq);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_b", 32'(add_b), 32'd0);
      chk("rst_add_cin", 32'(add_cin), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run16("inc",    16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 4'b0000, 0);
      run16("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110, 0);
      run16("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111, 0);
      run16("zero",   16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000, 0);
      run16("bp",     16'h5A5A, 16'h1111, 1'b0, 16'h6B6B, 1'b0, 4'b0000, 3);

      // Reset pulse during the second RUN cycle
      in_valid = 1'b1;
      opa      = 16'h1111;
      opb      = 16'h2222;
      cin      = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_add_a", 32'(add_a), 32'd0);
      chk("mrst_add_b", 32'(add_b), 32'd0);
      chk("mrst_add_cin", 32'(add_cin), 32'd0);
      chk("mrst_result", 32'(result), 32'd0);
      chk("mrst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mrst_no_valid", 32'(out_valid), 32'd0);
      end
      $display("txn mrst: transaction discarded by reset");
      run16("post_rst", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 4'b1100, 0);

      // Single-chunk instance
      in_valid4 = 1'b1;
      opa4      = 4'h9;
      opb4      = 4'h8;
      cin4      = 1'b0;
      chk("k1_in_ready", 32'(in_ready4), 32'd1);
      @(negedge clk);
      in_valid4 = 1'b0;
      opa4      = 4'h0;
      opb4      = 4'h0;
      chk("k1_out_valid_run", 32'(out_valid4), 32'd0);
      chk("k1_add_a", 32'(add_a4), 32'h9);
      chk("k1_add_b", 32'(add_b4), 32'h8);
      @(negedge clk);
      chk("k1_out_valid", 32'(out_valid4), 32'd1);
      chk("k1_result", 32'(result4), 32'h1);
      chk("k1_cout", 32'(cout4), 32'd1);
      @(negedge clk);
      chk("k1_idle", 32'(in_ready4), 32'd1);
      $display("txn k1: A=9 B=8 Cin=0 -> result=%h Cout=%b", result4, cout4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
